// File: rtl/video_word_packer.sv
// -----------------------------------------------------------------------------
// video_word_packer
//
// Input stage feeding the bank distributor. Collects one HDMI pixel per clock
// on every colour channel while DE is high. It packs PACK_FACTOR consecutive
// pixels per channel into one CHANNEL_BANDWIDTH-wide word, little-endian, so
// the first pixel sits in the LSBs. Each word is presented with a sequential
// global write address. A rising VSYNC edge starts a frame. After FRAME_WORDS
// words the frame is full, and further pixels only raise a sticky overflow
// flag.
//
// Optional feature (compile-time macro PACKER_LINE_ALIGN_EN):
//   A DE falling edge in the middle of a word flushes the partial word, with
//   the unfilled upper slots set to zero. Each video line then starts on a
//   word boundary. Without the macro, partial words carry across DE gaps and
//   no DE history register exists.
//
// Ports:
//   I_clk_in          : clock, all logic on the rising edge
//   I_rst_in          : synchronous active-high reset
//   I_de_in           : pixel valid (HDMI data enable)
//   I_vsync_in        : active-high vertical sync, rising edge starts a frame
//   I_pixel_in[c]     : current pixel component of channel c
//   O_data_out[c]     : packed word of channel c (held between strobes)
//   O_address_out     : word address of O_data_out (held between strobes)
//   O_valid_out       : one-cycle strobe, a new word is on O_data_out
//   O_frame_done_out  : one-cycle pulse together with the valid of the last word
//   O_overflow_out    : sticky, a pixel arrived after the frame was full
// -----------------------------------------------------------------------------
module video_word_packer #(
  parameter int  CHANNEL_NUMBER    = 3,
  parameter int  PIXEL_BITS        = 8,
  parameter int  PACK_FACTOR       = 4,
  parameter int  FRAME_WORDS       = 36,
  localparam int CHANNEL_BANDWIDTH = PIXEL_BITS * PACK_FACTOR,
  localparam int GLOBAL_ADDR_BITS  = $clog2(FRAME_WORDS)
) (
  input  logic                         I_clk_in,
  input  logic                         I_rst_in,
  input  logic                         I_de_in,
  input  logic                         I_vsync_in,
  input  logic [PIXEL_BITS-1:0]        I_pixel_in    [0:CHANNEL_NUMBER-1],
  output logic [CHANNEL_BANDWIDTH-1:0] O_data_out    [0:CHANNEL_NUMBER-1],
  output logic [GLOBAL_ADDR_BITS-1:0]  O_address_out,
  output logic                         O_valid_out,
  output logic                         O_frame_done_out,
  output logic                         O_overflow_out
);

  localparam int LANE_BITS = (PACK_FACTOR > 1) ? $clog2(PACK_FACTOR) : 1;
  localparam logic [LANE_BITS-1:0]        LAST_LANE = LANE_BITS'(PACK_FACTOR - 1);
  localparam logic [GLOBAL_ADDR_BITS-1:0] LAST_ADDR = GLOBAL_ADDR_BITS'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    WAIT_VSYNC,
    ACTIVE,
    FULL
  } state_e;

  state_e                        state_q,   state_d;
  logic [LANE_BITS-1:0]          lane_q,    lane_d;
  logic [GLOBAL_ADDR_BITS-1:0]   addr_q,    addr_d;
  logic                          vsync_q;
  logic [CHANNEL_BANDWIDTH-1:0]  buf_q     [0:CHANNEL_NUMBER-1];
  logic [CHANNEL_BANDWIDTH-1:0]  buf_d     [0:CHANNEL_NUMBER-1];
  logic [CHANNEL_BANDWIDTH-1:0]  data_q    [0:CHANNEL_NUMBER-1];
  logic [CHANNEL_BANDWIDTH-1:0]  data_d    [0:CHANNEL_NUMBER-1];
  logic [GLOBAL_ADDR_BITS-1:0]   address_q, address_d;
  logic                          valid_q,   valid_d;
  logic                          done_q,    done_d;
  logic                          overflow_q, overflow_d;

  // Word candidate: the shift buffer plus the pixel being sampled this cycle.
  logic [CHANNEL_BANDWIDTH-1:0]  word_w    [0:CHANNEL_NUMBER-1];
  logic                          emit_w;
  logic                          vsync_rise_w;

`ifdef PACKER_LINE_ALIGN_EN
  logic                          de_q;
  logic                          de_fall_w;
  assign de_fall_w = ~I_de_in & de_q;
`endif

  // A vsync held high across reset release is seen as a rise, because
  // vsync_q is reset to 0.
  assign vsync_rise_w = I_vsync_in & ~vsync_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d    = state_q;
    lane_d     = lane_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    data_d     = data_q;
    address_d  = address_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    word_w     = buf_q;
    emit_w     = 1'b0;

    if (vsync_rise_w) begin
      // A new frame wins over everything. A partial word and any pixel that
      // coincides with the rise are dropped.
      state_d = ACTIVE;
      lane_d  = '0;
      addr_d  = '0;
      for (int c = 0; c < CHANNEL_NUMBER; c++) buf_d[c] = '0;
    end else begin
      unique case (state_q)
        WAIT_VSYNC: begin
          // DE activity is ignored until a frame starts.
        end
        ACTIVE: begin
          if (I_de_in) begin
            // NOTE: always_comb uses blocking assignments, so the
            // slot insert below is visible to the lines after it.
            for (int c = 0; c < CHANNEL_NUMBER; c++) begin
              for (int s = 0; s < PACK_FACTOR; s++) begin
                if (lane_q == LANE_BITS'(s))
                  word_w[c][s*PIXEL_BITS +: PIXEL_BITS] = I_pixel_in[c];
              end
            end
            if (lane_q == LAST_LANE) begin
              emit_w = 1'b1;
            end else begin
              buf_d  = word_w;
              lane_d = lane_q + 1'b1;
            end
          end
`ifdef PACKER_LINE_ALIGN_EN
          else if (de_fall_w && (lane_q != '0)) begin
            // The buffer is cleared at every word start, so the unfilled
            // upper slots are already zero.
            emit_w = 1'b1;
          end
`endif
        end
        FULL: begin
          if (I_de_in) overflow_d = 1'b1;
        end
        default: begin
          state_d = WAIT_VSYNC;
        end
      endcase

      if (emit_w) begin
        data_d    = word_w;
        address_d = addr_q;
        valid_d   = 1'b1;
        lane_d    = '0;
        for (int c = 0; c < CHANNEL_NUMBER; c++) buf_d[c] = '0;
        if (addr_q == LAST_ADDR) begin
          // The frame is complete. The address parks on the last word.
          done_d  = 1'b1;
          state_d = FULL;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge I_clk_in) begin
    if (I_rst_in) begin
      state_q    <= WAIT_VSYNC;
      lane_q     <= '0;
      addr_q     <= '0;
      vsync_q    <= 1'b0;
      address_q  <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      // NOTE: the word buffers are plain flops, not a RAM. They are reset
      // so that the outputs read 0 after reset and flushed words start
      // from zero.
      for (int c = 0; c < CHANNEL_NUMBER; c++) begin
        buf_q[c]  <= '0;
        data_q[c] <= '0;
      end
`ifdef PACKER_LINE_ALIGN_EN
      de_q       <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples its pre-edge next-state value.
      state_q    <= state_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      vsync_q    <= I_vsync_in;
      buf_q      <= buf_d;
      data_q     <= data_d;
      address_q  <= address_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
`ifdef PACKER_LINE_ALIGN_EN
      de_q       <= I_de_in;
`endif
    end
  end

  assign O_data_out       = data_q;
  assign O_address_out    = address_q;
  assign O_valid_out      = valid_q;
  assign O_frame_done_out = done_q;
  assign O_overflow_out   = overflow_q;

endmodule

// File: doc/video_word_packer.md
Name: video_word_packer

Overview:
- Input stage directly upstream of Bank_Distributor.
- Accepts one HDMI pixel per clock per colour channel, gated by DE and framed by VSYNC.
- Packs PACK_FACTOR consecutive pixels per channel into one CHANNEL_BANDWIDTH-wide word.
- Presents each word with a sequential global write address on the same I_data_in / I_address_in form the distributor consumes.

Parameters:
- CHANNEL_NUMBER, 3, number of colour channels (lanes), one packed word each.
- PIXEL_BITS, 8, bits per pixel component per channel.
- PACK_FACTOR, 4, pixels packed per output word; CHANNEL_BANDWIDTH = PIXEL_BITS*PACK_FACTOR (localparam).
- FRAME_WORDS, 36, words per frame; GLOBAL_ADDR_BITS = $clog2(FRAME_WORDS) (localparam).

Ports:
- I_clk_in, input, 1, single clock; all logic on rising edge.
- I_rst_in, input, 1, synchronous active-high reset.
- I_de_in, input, 1, pixel valid (HDMI data enable).
- I_vsync_in, input, 1, active-high vertical sync; a rising edge starts a frame.
- I_pixel_in, input, [PIXEL_BITS-1:0] x CHANNEL_NUMBER (unpacked array [0:CHANNEL_NUMBER-1]), current pixel per channel.
- O_data_out, output, [CHANNEL_BANDWIDTH-1:0] x CHANNEL_NUMBER, packed words.
- O_address_out, output, GLOBAL_ADDR_BITS, word address of O_data_out.
- O_valid_out, output, 1, one-cycle strobe: O_data_out/O_address_out are a new word.
- O_frame_done_out, output, 1, one-cycle pulse, coincident with the valid of word FRAME_WORDS-1.
- O_overflow_out, output, 1, sticky: a pixel arrived after the frame was full.

Behaviour:
- Clocking/reset: one clock domain; reset is synchronous and active-high.
- Reset values: all outputs 0; lane counter 0; address counter 0; vsync history register 0; state WAIT_VSYNC.
- VSYNC edge detect: vsync_rise = I_vsync_in & ~vsync_q.
  - vsync held high across reset release counts as a rise on the first post-reset cycle.
- States: WAIT_VSYNC, ACTIVE, FULL.
- WAIT_VSYNC:
  - DE pixels are ignored.
  - vsync_rise -> ACTIVE; lane=0, addr=0.
- ACTIVE, each cycle with I_de_in=1:
  - Write pixel into slot [lane*PIXEL_BITS +: PIXEL_BITS] of each channel's shift buffer.
  - Packing is little-endian: the first pixel lands in the LSBs.
  - lane increments.
- Word complete (lane==PACK_FACTOR-1 with DE):
  - On that same edge, register the full word into O_data_out and addr into O_address_out, and set O_valid_out=1.
  - Latency: the word is visible in the cycle after the last pixel is sampled.
  - Then lane=0, addr+1.
- DE low mid-word: the partial word is retained; lanes continue with the next DE pixel, across line boundaries.
- Last word (addr==FRAME_WORDS-1) emitted: O_frame_done_out=1 for the same cycle; next state FULL; addr stays FRAME_WORDS-1 and does not wrap.
- FULL:
  - DE pixels are discarded and set O_overflow_out=1.
  - No valid strobes.
  - vsync_rise -> ACTIVE; lane=0, addr=0.
- vsync_rise in any state:
  - Any partial word is discarded.
  - If I_de_in=1 on the same cycle, vsync wins and that pixel is dropped.
- Output hold: O_data_out and O_address_out hold their last values while O_valid_out=0; O_valid_out and O_frame_done_out are never high for more than one consecutive cycle unless back-to-back words complete.
- O_overflow_out: cleared only by reset, not by vsync.
- Reset mid-frame: same as power-on reset; the partial word is lost; DE activity is ignored until the next vsync_rise.

Optional Feature:
- Macro: PACKER_LINE_ALIGN_EN.
- Defined:
  - In ACTIVE, a DE falling edge (I_de_in=0 while previous DE=1) with lane!=0 flushes the partial word.
  - Unfilled upper slots are zero; the word is emitted as a normal valid strobe with the next address (frame_done/FULL rules apply); lane=0.
  - Lines start word-aligned.
- Undefined: partial words carry over DE gaps as above; no DE history register is synthesised.

Test Plan:
- Reset state: assert I_rst_in 2 cycles, then DE=1 for 8 cycles with no vsync -> all outputs 0, O_valid_out never 1.
- Basic pack: vsync pulse, then ch0 pixels 0x11,0x22,0x33,0x44 on 4 DE cycles (ch1 0xA0..0xA3, ch2 0x00) -> one cycle after the 4th pixel: O_valid_out=1, O_address_out=0, O_data_out[0]=0x44332211, O_data_out[1]=0xA3A2A1A0, O_data_out[2]=0.
- Full frame: vsync, 144 continuous DE pixels -> 36 valid strobes, addresses 0..35, O_frame_done_out=1 with addr 35; then 1 extra DE pixel -> O_overflow_out=1, no valid; new vsync then 4 pixels -> addr 0, overflow still 1.
- DE gap: pixels 0x11,0x22, DE low 5 cycles, then 0x33,0x44 -> without macro: single word 0x44332211 at addr 0; with PACKER_LINE_ALIGN_EN: 0x00002211 at addr 0 and 0x00004433 at addr 1.
- VSYNC mid-word: 3 pixels, vsync rise coincident with a 4th DE pixel, then 0x55,0x66,0x77,0x88 -> only word 0x88776655 at addr 0; the coincident pixel is absent.
- Reset mid-frame: after 10 words, I_rst_in 1 cycle -> outputs 0 next cycle; subsequent 4 DE pixels with no vsync produce no valid.
